// File: rtl/fifo_pair_reader.sv
// Drains a show-ahead FIFO and packs consecutive words into (A,B) pairs
// presented on a valid/ready stream; counts accepted pairs.
module fifo_pair_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_SIZE   = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   input  logic [PTR_SIZE:0]     fifo_count,
   output logic                  fifo_re_en,
   input  logic                  enable,
   input  logic                  pair_wait,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic [CNT_WIDTH-1:0]  pair_cnt,
   output logic                  half
);

   typedef enum logic [1:0] {S_A, S_B, S_OUT} state_t;

   localparam logic [PTR_SIZE:0] TWO_WORDS = (PTR_SIZE+1)'(2);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  accept;
   logic                  can_start;
   logic                  pop;

   assign accept    = (state_q == S_OUT) & out_ready;
   // Starting a new pair may require both words to be present already.
   assign can_start = enable & ~fifo_empty & (~pair_wait | (fifo_count >= TWO_WORDS));

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      pop        = 1'b0;
      fifo_re_en = 1'b0;
      case (state_q)
         S_A:     pop = can_start;
         S_B:     pop = enable & ~fifo_empty;
         S_OUT:   pop = accept & can_start;
         default: pop = 1'b0;
      endcase
      fifo_re_en = pop & ~flush & ~rst;
      if (flush) begin
         state_d = S_A;
      end else begin
         case (state_q)
            S_A: begin
               if (fifo_re_en) begin
                  a_d     = fifo_data;
                  state_d = S_B;
               end
            end
            S_B: begin
               if (fifo_re_en) begin
                  b_d     = fifo_data;
                  state_d = S_OUT;
               end
            end
            S_OUT: begin
               if (accept) begin
                  if (fifo_re_en) begin
                     a_d     = fifo_data;
                     state_d = S_B;
                  end else begin
                     state_d = S_A;
                  end
               end
            end
            default: state_d = S_A;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         if (accept) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign out_valid = (state_q == S_OUT);
   assign half      = (state_q == S_B);
   assign out_a     = a_q;
   assign out_b     = b_q;
   assign pair_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_pair_reader.sv
// Directed bench for fifo_pair_reader with a behavioural show-ahead FIFO
// model and a pair monitor on the output stream.
module tb_fifo_pair_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic [5:0] fifo_count;
   logic       fifo_re_en;
   logic       enable;
   logic       pair_wait;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_a;
   logic [7:0] out_b;
   logic [3:0] pair_cnt;
   logic       half;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [64];
   int wr = 0;
   int rd = 0;
   int pops = 0;
   int viol = 0;
   int cyc = 0;
   int np = 0;
   logic [7:0] pa [64];
   logic [7:0] pb [64];
   int pc [64];

   always #5 clk = ~clk;

   fifo_pair_reader #(.DATA_WIDTH(8), .PTR_SIZE(5), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_count(fifo_count), .fifo_re_en(fifo_re_en), .enable(enable),
      .pair_wait(pair_wait), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .pair_cnt(pair_cnt), .half(half)
   );

   // Show-ahead FIFO: data is X whenever the FIFO is empty.
   assign fifo_empty = (wr == rd);
   assign fifo_count = 6'(wr - rd);
   assign fifo_data  = fifo_empty ? 8'hxx : mem[rd % 64];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_re_en) begin
         rd   <= rd + 1;
         pops <= pops + 1;
         if (fifo_empty) viol <= viol + 1;
      end
      if (!rst && out_valid && out_ready) begin
         pa[np] <= out_a;
         pb[np] <= out_b;
         pc[np] <= cyc;
         np     <= np + 1;
      end
   end

   task automatic push(input logic [7:0] v);
      mem[wr % 64] = v;
      wr = wr + 1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_pair(input int idx, input logic [7:0] ea, input logic [7:0] eb);
      check($sformatf("pair%0d_a", idx), {24'd0, pa[idx]}, {24'd0, ea});
      check($sformatf("pair%0d_b", idx), {24'd0, pb[idx]}, {24'd0, eb});
   endtask

   int p0;
   int c0;
   initial begin
      rst = 1'b1; enable = 1'b1; pair_wait = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_half",  32'(half), 32'd0);
      check("rst_a",     32'(out_a), 32'd0);
      check("rst_b",     32'(out_b), 32'd0);
      check("rst_cnt",   32'(pair_cnt), 32'd0);
      check("rst_re",    32'(fifo_re_en), 32'd0);
      rst = 1'b0;

      // basic pairing
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      repeat (6) tick();
      check("basic_np", 32'(np), 32'd2);
      check_pair(0, 8'h11, 8'h22);
      check_pair(1, 8'h33, 8'h44);
      check("basic_cnt", 32'(pair_cnt), 32'd2);
      check("basic_pops", 32'(pops), 32'd4);
      check("basic_empty", 32'(fifo_empty), 32'd1);

      // backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
      tick(); tick();
      check("bp_pops", 32'(pops), 32'd6);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_a", 32'(out_a), 32'hA0);
         check("bp_b", 32'(out_b), 32'hA1);
         check("bp_re", 32'(fifo_re_en), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1 check("bp_b2b_re", 32'(fifo_re_en), 32'd1);
      repeat (6) tick();
      check("bp_np", 32'(np), 32'd5);
      check_pair(2, 8'hA0, 8'hA1);
      check_pair(3, 8'hA2, 8'hA3);
      check_pair(4, 8'hA4, 8'hA5);
      check("bp_rate1", 32'(pc[3] - pc[2]), 32'd2);
      check("bp_rate2", 32'(pc[4] - pc[3]), 32'd2);

      // empty guard and odd word
      push(8'h5A);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("odd_half", 32'(half), 32'd1);
         check("odd_valid", 32'(out_valid), 32'd0);
         check("odd_re", 32'(fifo_re_en), 32'd0);
         tick();
      end
      push(8'h5B);
      repeat (3) tick();
      check_pair(5, 8'h5A, 8'h5B);

      // pair_wait
      pair_wait = 1'b1;
      push(8'h01);
      p0 = pops;
      for (int i = 0; i < 3; i++) begin
         check("pw_half", 32'(half), 32'd0);
         check("pw_re", 32'(fifo_re_en), 32'd0);
         tick();
      end
      check("pw_nopop", 32'(pops), 32'(p0));
      push(8'h02);
      #1 check("pw_re2", 32'(fifo_re_en), 32'd1);
      tick();
      check("pw_half2", 32'(half), 32'd1);
      tick();
      check("pw_valid", 32'(out_valid), 32'd1);
      tick();
      check_pair(6, 8'h01, 8'h02);
      pair_wait = 1'b0;

      // flush in S_B
      push(8'h77);
      tick();
      check("fb_half", 32'(half), 32'd1);
      c0 = 32'(pair_cnt);
      push(8'h88);
      flush = 1'b1;
      #1 check("fb_re", 32'(fifo_re_en), 32'd0);
      p0 = pops;
      tick();
      flush = 1'b0;
      check("fb_half0", 32'(half), 32'd0);
      check("fb_nopop", 32'(pops), 32'(p0));
      check("fb_cnt", 32'(pair_cnt), 32'(c0));
      push(8'h99);
      repeat (3) tick();
      check_pair(7, 8'h88, 8'h99);

      // flush in S_OUT
      out_ready = 1'b0;
      push(8'hC1); push(8'hC2);
      tick(); tick();
      check("fo_valid1", 32'(out_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fo_valid0", 32'(out_valid), 32'd0);
      check("fo_half", 32'(half), 32'd0);
      check("fo_a", 32'(out_a), 32'hC1);
      check("fo_b", 32'(out_b), 32'hC2);
      check("fo_np", 32'(np), 32'd8);

      // reset mid-stream
      push(8'hD1); push(8'hD2);
      tick(); tick();
      check("rm_valid1", 32'(out_valid), 32'd1);
      push(8'hD3);
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("rm_valid", 32'(out_valid), 32'd0);
      check("rm_cnt", 32'(pair_cnt), 32'd0);
      check("rm_a", 32'(out_a), 32'd0);
      check("rm_b", 32'(out_b), 32'd0);
      check("rm_re", 32'(fifo_re_en), 32'd0);
      p0 = pops;
      repeat (2) begin
         tick();
         check("rm_re_hold", 32'(fifo_re_en), 32'd0);
      end
      check("rm_nopop", 32'(pops), 32'(p0));
      rst = 1'b0;

      // counter wrap: D3 plus 33 more words make 17 pairs
      for (int i = 0; i < 33; i++) push(8'(i));
      repeat (40) tick();
      check("wrap_cnt", 32'(pair_cnt), 32'd1);
      check("wrap_empty", 32'(fifo_empty), 32'd1);
      check_pair(8, 8'hD3, 8'h00);
      check("no_empty_pop", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
